// File: rtl/pattern_pkg.sv
// Shared constants for the HUB75 test-pattern writer: pattern modes, FSM states
// and the colour-cycle step used by the solid-fill pattern.
package pattern_pkg;

  localparam logic [1:0] MODE_SOLID    = 2'd0;
  localparam logic [1:0] MODE_GRADIENT = 2'd1;
  localparam logic [1:0] MODE_CHECKER  = 2'd2;
  localparam logic [1:0] MODE_SCROLL   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_SWAP = 2'd2
  } state_e;

  // Solid colour sequence red -> green -> blue -> red.
  function automatic logic [1:0] next_colour(input logic [1:0] colour);
    return (colour == 2'd2) ? 2'd0 : colour + 2'd1;
  endfunction

endpackage

// File: rtl/pattern_pixel.sv
// Combinational pixel generator: maps (x, y, phase, colour cycle) to an {r,g,b}
// word for the selected pattern mode. The caller registers the result.
module pattern_pixel
  import pattern_pkg::*;
#(
  parameter int ADDR_W    = 12,
  parameter int COLS_LOG2 = 6,
  parameter int CH_W      = 4
) (
  input  logic [1:0]                  mode,
  input  logic [COLS_LOG2-1:0]        x,
  input  logic [ADDR_W-COLS_LOG2-1:0] y,
  input  logic [7:0]                  phase,
  input  logic [1:0]                  colour,
  output logic [3*CH_W-1:0]           pixel
);

  localparam int ROWS_LOG2 = ADDR_W - COLS_LOG2;
  localparam logic [CH_W-1:0] FULL = '1;
  localparam logic [CH_W-1:0] NONE = '0;

  logic [COLS_LOG2-1:0] p_cols;
  logic [COLS_LOG2-1:0] x_plus_p;
  logic [CH_W-1:0]      grad_r;
  logic [CH_W-1:0]      grad_g;

  // Phase arithmetic wraps at the column width so the checker scrolls seamlessly.
  assign p_cols   = COLS_LOG2'(phase);
  assign x_plus_p = x + p_cols;
  assign grad_r   = CH_W'(x >> (COLS_LOG2 - CH_W));
  assign grad_g   = CH_W'(y >> (ROWS_LOG2 - CH_W));

  always_comb begin
    pixel = '0;
    case (mode)
      MODE_SOLID: begin
        case (colour)
          2'd0:    pixel = {FULL, NONE, NONE};
          2'd1:    pixel = {NONE, FULL, NONE};
          default: pixel = {NONE, NONE, FULL};
        endcase
      end
      MODE_GRADIENT: pixel = {grad_r, grad_g, NONE};
      MODE_CHECKER: begin
        if (x_plus_p[3] ^ y[3]) pixel = '1;
      end
      default: begin
        if (x == p_cols) pixel = '1;
      end
    endcase
  end

endmodule

// File: rtl/pattern_writer.sv
// Fills the back bank of the double-buffered panel RAM with a generated pattern
// once per prescaler tick, then hands the bank to the driver via a swap handshake.
module pattern_writer
  import pattern_pkg::*;
#(
  parameter int ADDR_W    = 12,
  parameter int COLS_LOG2 = 6,
  parameter int CH_W      = 4,
  parameter int PRESCALE  = 375000
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic [1:0]          i_mode,
  input  logic                i_swap_ack,
  output logic [ADDR_W:0]     o_ram_w_addr,
  output logic [3*CH_W-1:0]   o_ram_w_data,
  output logic                o_ram_w_enable,
  output logic                o_bank,
  output logic                o_swap_req,
  output logic [7:0]          o_frame_count,
  output logic                o_busy,
  output logic                o_overrun
);

  localparam int PRE_W = $clog2(PRESCALE);
  localparam logic [PRE_W-1:0]  PRE_RELOAD = PRE_W'(PRESCALE - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = '1;

  state_e              state_q, state_d;
  logic [PRE_W-1:0]    presc_q, presc_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          mode_q, mode_d;
  logic [7:0]          phase_q, phase_d;
  logic [1:0]          colour_q, colour_d;
  logic                bank_q, bank_d;
  logic                swap_req_q, swap_req_d;
  logic [7:0]          count_q, count_d;
  logic                overrun_q, overrun_d;
  logic                w_en_q, w_en_d;
  logic [ADDR_W:0]     w_addr_q, w_addr_d;
  logic [3*CH_W-1:0]   w_data_q, w_data_d;
  logic [3*CH_W-1:0]   pixel;

  logic tick, frame_start, ack_take;

  assign tick        = (presc_q == '0);
  assign frame_start = (state_q == ST_IDLE) && tick && i_enable;
  // Acks are only honoured once the request is visible, so an ack held high
  // early is taken on the first request cycle.
  assign ack_take    = (state_q == ST_SWAP) && swap_req_q && i_swap_ack;

  pattern_pixel #(
    .ADDR_W    (ADDR_W),
    .COLS_LOG2 (COLS_LOG2),
    .CH_W      (CH_W)
  ) u_pixel (
    .mode   (mode_q),
    .x      (addr_q[COLS_LOG2-1:0]),
    .y      (addr_q[ADDR_W-1:COLS_LOG2]),
    .phase  (phase_q),
    .colour (colour_q),
    .pixel  (pixel)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (frame_start)          state_d = ST_FILL;
      ST_FILL: if (addr_q == LAST_ADDR)  state_d = ST_SWAP;
      ST_SWAP: if (ack_take)             state_d = ST_IDLE;
      default:                           state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    presc_d    = tick ? PRE_RELOAD : presc_q - PRE_W'(1);
    mode_d     = frame_start ? i_mode : mode_q;
    addr_d     = (state_q == ST_FILL) ? addr_q + ADDR_W'(1) : '0;
    w_en_d     = (state_q == ST_FILL);
    w_addr_d   = (state_q == ST_FILL) ? {~bank_q, addr_q} : w_addr_q;
    w_data_d   = (state_q == ST_FILL) ? pixel : w_data_q;
    swap_req_d = (state_q == ST_SWAP) && !ack_take;
    overrun_d  = tick && (state_q != ST_IDLE);
    bank_d     = bank_q;
    count_d    = count_q;
    phase_d    = phase_q;
    colour_d   = colour_q;
    if (ack_take) begin
      bank_d   = ~bank_q;
      count_d  = count_q + 8'd1;
      phase_d  = phase_q + 8'd1;
      colour_d = next_colour(colour_q);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      presc_q    <= PRE_RELOAD;
      addr_q     <= '0;
      mode_q     <= MODE_SOLID;
      phase_q    <= '0;
      colour_q   <= '0;
      bank_q     <= 1'b0;
      swap_req_q <= 1'b0;
      count_q    <= '0;
      overrun_q  <= 1'b0;
      w_en_q     <= 1'b0;
      w_addr_q   <= '0;
      w_data_q   <= '0;
    end else begin
      presc_q    <= presc_d;
      addr_q     <= addr_d;
      mode_q     <= mode_d;
      phase_q    <= phase_d;
      colour_q   <= colour_d;
      bank_q     <= bank_d;
      swap_req_q <= swap_req_d;
      count_q    <= count_d;
      overrun_q  <= overrun_d;
      w_en_q     <= w_en_d;
      w_addr_q   <= w_addr_d;
      w_data_q   <= w_data_d;
    end
  end

  assign o_ram_w_addr   = w_addr_q;
  assign o_ram_w_data   = w_data_q;
  assign o_ram_w_enable = w_en_q;
  assign o_bank         = bank_q;
  assign o_swap_req     = swap_req_q;
  assign o_frame_count  = count_q;
  assign o_busy         = (state_q != ST_IDLE);
  assign o_overrun      = overrun_q;

endmodule

// File: tb/tb_pattern_writer.sv
// Scoreboard bench for pattern_writer: stimulus pushes the expected frame writes,
// a negedge monitor pops and checks each RAM write plus its cycle position.
module tb_pattern_writer;

  localparam int ADDR_W    = 8;
  localparam int COLS_LOG2 = 4;
  localparam int CH_W      = 4;
  localparam int PRESCALE  = 400;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_enable = 1'b1;
  logic [1:0]  i_mode = 2'd0;
  logic        i_swap_ack = 1'b1;
  logic [8:0]  o_ram_w_addr;
  logic [11:0] o_ram_w_data;
  logic        o_ram_w_enable;
  logic        o_bank;
  logic        o_swap_req;
  logic [7:0]  o_frame_count;
  logic        o_busy;
  logic        o_overrun;

  pattern_writer #(
    .ADDR_W(ADDR_W), .COLS_LOG2(COLS_LOG2), .CH_W(CH_W), .PRESCALE(PRESCALE)
  ) dut (
    .i_clk          (clk),
    .i_reset        (i_reset),
    .i_enable       (i_enable),
    .i_mode         (i_mode),
    .i_swap_ack     (i_swap_ack),
    .o_ram_w_addr   (o_ram_w_addr),
    .o_ram_w_data   (o_ram_w_data),
    .o_ram_w_enable (o_ram_w_enable),
    .o_bank         (o_bank),
    .o_swap_req     (o_swap_req),
    .o_frame_count  (o_frame_count),
    .o_busy         (o_busy),
    .o_overrun      (o_overrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [8:0]  addr;
    logic [11:0] data;
  } wr_t;

  wr_t         exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          rst_edge = 0;
  int          last_wr_cyc = 0;
  int          ovr_cnt = 0;
  logic        prev_ovr = 1'b0;
  logic [11:0] cap_95 = '0;
  logic [11:0] cap_ff = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [11:0] model_pixel(input logic [1:0] m, input logic [3:0] x,
                                              input logic [3:0] y, input logic [7:0] p,
                                              input logic [1:0] c);
    logic [3:0] xp;
    xp = x + p[3:0];
    case (m)
      2'd0:    return (c == 2'd0) ? 12'hF00 : (c == 2'd1) ? 12'h0F0 : 12'h00F;
      2'd1:    return {x, y, 4'h0};
      2'd2:    return (xp[3] ^ y[3]) ? 12'hFFF : 12'h000;
      default: return (x == p[3:0]) ? 12'hFFF : 12'h000;
    endcase
  endfunction

  task automatic push_frame(input logic bank_bit, input logic [1:0] m,
                            input logic [7:0] p, input logic [1:0] c);
    for (int a = 0; a < 256; a++) begin
      logic [7:0] a8;
      wr_t w;
      a8 = 8'(a);
      w.addr = {bank_bit, a8};
      w.data = model_pixel(m, a8[3:0], a8[7:4], p, c);
      exp_q.push_back(w);
    end
  endtask

  task automatic wait_count(input logic [7:0] target, input int budget);
    for (int i = 0; i < budget && o_frame_count !== target; i++) @(negedge clk);
    check("frame_count", 32'(o_frame_count), 32'(target));
    $display("frame %0d swapped at cycle %0d, front bank %0d", o_frame_count, cyc, o_bank);
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (i_reset) rst_edge <= cyc + 1;
  end

  // Monitor: every visible write is popped against the scoreboard and its
  // cycle position checked against the tick grid set by the last reset.
  always @(negedge clk) begin
    if (o_overrun) begin
      ovr_cnt++;
      check("overrun_one_cycle", 32'(prev_ovr), 32'd0);
    end
    prev_ovr = o_overrun;
    if (o_ram_w_enable) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write_addr", 32'(o_ram_w_addr), 32'h1FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("w_addr", 32'(o_ram_w_addr), 32'(e.addr));
        check("w_data", 32'(o_ram_w_data), 32'(e.data));
      end
      if (o_ram_w_addr[7:0] == 8'h00)
        check("frame_start_offset", 32'((cyc - rst_edge) % PRESCALE), 32'd1);
      else
        check("write_contiguous", 32'(cyc - last_wr_cyc), 32'd1);
      last_wr_cyc = cyc;
      if (o_ram_w_addr[7:0] == 8'h95) cap_95 = o_ram_w_data;
      if (o_ram_w_addr[7:0] == 8'hFF) cap_ff = o_ram_w_data;
    end
  end

  initial begin
    int ovr_snap;
    int bad;
    repeat (3) @(negedge clk);
    i_reset = 1'b0;
    check("reset_w_enable", 32'(o_ram_w_enable), 32'd0);
    check("reset_w_addr", 32'(o_ram_w_addr), 32'd0);
    check("reset_w_data", 32'(o_ram_w_data), 32'd0);
    check("reset_bank", 32'(o_bank), 32'd0);
    check("reset_swap_req", 32'(o_swap_req), 32'd0);
    check("reset_count", 32'(o_frame_count), 32'd0);
    check("reset_busy", 32'(o_busy), 32'd0);
    check("reset_overrun", 32'(o_overrun), 32'd0);

    // Solid colour cycle with ack tied high.
    push_frame(1'b1, 2'd0, 8'd0, 2'd0);
    wait_count(8'd1, 3000);
    check("bank_f1", 32'(o_bank), 32'd1);
    push_frame(1'b0, 2'd0, 8'd1, 2'd1);
    wait_count(8'd2, 3000);
    check("bank_f2", 32'(o_bank), 32'd0);
    push_frame(1'b1, 2'd0, 8'd2, 2'd2);
    wait_count(8'd3, 3000);
    push_frame(1'b0, 2'd0, 8'd3, 2'd0);
    wait_count(8'd4, 3000);
    check("bank_f4", 32'(o_bank), 32'd0);

    // Gradient frame.
    i_mode = 2'd1;
    push_frame(1'b1, 2'd1, 8'd4, 2'd1);
    wait_count(8'd5, 3000);
    check("grad_pixel_95", 32'(cap_95), 32'h590);
    check("grad_pixel_ff", 32'(cap_ff), 32'hFF0);
    check("no_overrun_yet", 32'(ovr_cnt), 32'd0);

    // Withheld ack: request must hold, ticks overrun, no writes.
    i_mode = 2'd0;
    i_swap_ack = 1'b0;
    push_frame(1'b0, 2'd0, 8'd5, 2'd2);
    for (int i = 0; i < 1000 && !o_swap_req; i++) @(negedge clk);
    check("swap_req_rise", 32'(o_swap_req), 32'd1);
    ovr_snap = ovr_cnt;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (!o_swap_req || !o_busy) bad++;
    end
    check("swap_req_held", 32'(bad), 32'd0);
    check("overruns_in_hold", 32'((ovr_cnt - ovr_snap >= 2) && (ovr_cnt - ovr_snap <= 3)), 32'd1);
    check("count_held", 32'(o_frame_count), 32'd5);
    check("bank_held", 32'(o_bank), 32'd1);
    i_swap_ack = 1'b1;
    wait_count(8'd6, 100);
    repeat (5) @(negedge clk);
    check("bank_single_toggle", 32'(o_bank), 32'd0);
    check("swap_req_dropped", 32'(o_swap_req), 32'd0);

    // Reset in the middle of a fill.
    push_frame(1'b1, 2'd0, 8'd6, 2'd0);
    for (int i = 0; i < 1000 && !(o_ram_w_enable && o_ram_w_addr[7:0] == 8'd50); i++)
      @(negedge clk);
    check("reached_write_50", 32'(o_ram_w_addr[7:0]), 32'd50);
    i_reset = 1'b1;
    @(negedge clk);
    i_reset = 1'b0;
    check("abort_w_enable", 32'(o_ram_w_enable), 32'd0);
    check("abort_bank", 32'(o_bank), 32'd0);
    check("abort_count", 32'(o_frame_count), 32'd0);
    exp_q.delete();

    // Mode change mid-frame only affects the following frame.
    push_frame(1'b1, 2'd0, 8'd0, 2'd0);
    for (int i = 0; i < 1000 && !(o_ram_w_enable && o_ram_w_addr[7:0] == 8'd100); i++)
      @(negedge clk);
    check("reached_write_100", 32'(o_ram_w_addr[7:0]), 32'd100);
    i_mode = 2'd3;
    wait_count(8'd1, 1000);
    check("bank_after_abort", 32'(o_bank), 32'd1);
    push_frame(1'b0, 2'd3, 8'd1, 2'd1);
    wait_count(8'd2, 1000);

    // Disabled: three ticks pass with nothing happening.
    i_enable = 1'b0;
    ovr_snap = ovr_cnt;
    bad = 0;
    for (int i = 0; i < 1300; i++) begin
      @(negedge clk);
      if (o_busy) bad++;
    end
    check("disabled_busy", 32'(bad), 32'd0);
    check("disabled_overrun", 32'(ovr_cnt - ovr_snap), 32'd0);
    check("disabled_count", 32'(o_frame_count), 32'd2);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pattern_writer.md
Name: pattern_writer

Overview:
Parametrised test-pattern frame writer for the HUB75 panel path. It fills the back bank of a double-buffered pixel RAM with one of four generated patterns, one frame per prescaler tick. It then requests a bank swap from the panel driver and waits for the driver's acknowledge at the driver's frame boundary. It replaces the ad-hoc single-colour RAM write loop in the top level.

Parameters:
ADDR_W, 12, log2 of words per bank; RAM write address is ADDR_W+1 bits (MSB = bank)
COLS_LOG2, 6, log2 of panel columns; x = addr[COLS_LOG2-1:0], y = addr[ADDR_W-1:COLS_LOG2]
CH_W, 4, bits per colour channel; pixel word = {r,g,b}, 3*CH_W bits; requires COLS_LOG2 >= CH_W and ADDR_W-COLS_LOG2 >= CH_W
PRESCALE, 375000, clock cycles between frame ticks; must be greater than 2^ADDR_W+4

Ports:
i_clk  in  1  system clock (48 MHz)
i_reset  in  1  synchronous, active-high reset
i_enable  in  1  allow new frames to start
i_mode  in  2  pattern select; sampled only at frame start
i_swap_ack  in  1  driver acknowledges bank swap
o_ram_w_addr  out  ADDR_W+1  {back bank, pixel addr}
o_ram_w_data  out  3*CH_W  pixel {r,g,b}
o_ram_w_enable  out  1  write strobe
o_bank  out  1  front bank the driver reads
o_swap_req  out  1  back bank complete, swap requested
o_frame_count  out  8  frames swapped, wraps 255->0
o_busy  out  1  high in FILL or SWAP
o_overrun  out  1  one-cycle pulse: tick dropped while busy

Behaviour:
- Reset: all outputs 0; prescaler = PRESCALE-1; phase = 0; colour cycle = 0; state IDLE. Reset mid-FILL/SWAP aborts; no further writes from the cycle after reset is sampled.
- Prescaler: free-running down-counter. Tick when it reaches 0, then reload PRESCALE-1. Runs regardless of state.
- FSM IDLE -> FILL -> SWAP -> IDLE:
- IDLE: on tick with i_enable=1, latch i_mode and go to FILL. On tick with i_enable=0, do nothing and no overrun.
- FILL: one write per cycle, contiguous, pixel addr 0 .. 2^ADDR_W-1, bank bit = ~o_bank. Outputs registered. Tick sampled at cycle T gives the first write (addr 0) at T+2 and the last at T+1+2^ADDR_W.
- SWAP: o_swap_req is high from the cycle after the last write until i_swap_ack is sampled high. An ack held high before req is accepted in the first req cycle. On the cycle after ack: o_bank toggles, swap_req drops, frame_count+1, phase+1, colour cycle advances 0->1->2->0, state returns to IDLE.
- Ticks in FILL/SWAP are dropped and pulse o_overrun for one cycle. i_swap_ack outside SWAP is ignored.
- Mode changes mid-frame have no effect until the next frame start.
- Patterns (full = all-ones CH_W, p = phase[7:0]):
- Mode 0 SOLID: colour cycle 0/1/2 gives red/green/blue full.
- Mode 1 GRADIENT: r = x >> (COLS_LOG2-CH_W); g = y >> (ADDR_W-COLS_LOG2-CH_W); b = 0.
- Mode 2 CHECKER: white when ((x+p) mod 2^COLS_LOG2)[3] ^ y[3], else black. Addition wraps at COLS_LOG2 bits.
- Mode 3 SCROLL: white when x == p[COLS_LOG2-1:0], else black.

Decomposition:
- Package pattern_pkg: mode constants (MODE_SOLID=0, MODE_GRADIENT=1, MODE_CHECKER=2, MODE_SCROLL=3) and FSM state encodings.
- One combinational sub-module, pattern_pixel: inputs mode, x, y, phase, colour cycle; output pixel word. Its output is registered in pattern_writer.

Test Plan:
(bench params: ADDR_W=8, COLS_LOG2=4, CH_W=4, PRESCALE=400)
- Reset, enable=1, mode 0, ack tied high -> frame 1 writes addr 0x100..0x1FF with data 0xF00, then o_bank=1 and frame_count=1. Frame 2 writes 0x000..0x0FF with 0x0F0; frame 3 writes 0x00F; frame 4 writes 0xF00. Each frame is exactly 256 consecutive write cycles.
- Mode 1 -> pixel addr 0x95 (x=5, y=9) written as 0x590; addr 0xFF written as 0xFF0.
- Ack withheld 1000 cycles -> swap_req held high, no writes, o_overrun pulses at each tick, frame_count unchanged. On ack: a single bank toggle and frame_count+1.
- Mode switched 0->3 during write 100 -> the rest of that frame stays solid. The next frame (p=1) writes 0xFFF only where x==1, else 0x000.
- i_reset asserted at write 50 -> the next cycle has w_enable=0, bank=0, frame_count=0. The first write follows 2 cycles after the next tick.
- i_enable=0 across 3 ticks -> no writes, no overrun, busy stays 0.
